// File: rtl/aes_core_arbiter_if.sv
// Bundles the request, response and AES-core signals of aes_core_arbiter.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface aes_core_arbiter_if;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_key, req0_data, req1_key, req1_data;
  logic         req0_decrypt, req1_decrypt;
  logic         rsp0_valid, rsp1_valid;
  logic [127:0] rsp0_data, rsp1_data;
  logic         rsp0_err, rsp1_err;
  logic         rsp0_ready, rsp1_ready;
  logic         core_start;
  logic [127:0] core_key, core_din;
  logic         core_decrypt;
  logic         core_done;
  logic [127:0] core_dout;
  logic         busy, grant_id;

  modport slave (
    input  req0_valid, req1_valid, req0_key, req0_data, req1_key, req1_data,
           req0_decrypt, req1_decrypt, rsp0_ready, rsp1_ready, core_done, core_dout,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
           rsp0_err, rsp1_err, core_start, core_key, core_din, core_decrypt, busy, grant_id
  );

  modport master (
    output req0_valid, req1_valid, req0_key, req0_data, req1_key, req1_data,
           req0_decrypt, req1_decrypt, rsp0_ready, rsp1_ready, core_done, core_dout,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
           rsp0_err, rsp1_err, core_start, core_key, core_din, core_decrypt, busy, grant_id
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core between two requesters.
// Optional WAIT timeout is built when AES_CORE_ARBITER_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | waiting for a request, ready offered to the granted requester
//   ISSUE | one-cycle core_start pulse, timer cleared
//   WAIT  | waiting for core_done (or timeout)
//   RESP  | holding the response until the owner takes it
module aes_core_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic               clock,
  input logic               reset,
  aes_core_arbiter_if.slave bus
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be within 2..65535");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e       state_q;
  logic         last_grant_q, grant_q, busy_q, core_start_q, dec_q;
  logic         rsp0_valid_q, rsp1_valid_q;
  logic [127:0] key_q, din_q, res_q;
  logic         grant_sel, accept, rsp_ready_sel;

`ifdef AES_CORE_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] timer_q;
  logic        err_q;
`endif

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_sel = ~last_grant_q;
    else if (bus.req1_valid)              grant_sel = 1'b1;
  end

  assign accept        = (state_q == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
  assign rsp_ready_sel = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready   = accept & ~grant_sel;
  assign bus.req1_ready   = accept &  grant_sel;
  assign bus.core_start   = core_start_q;
  assign bus.core_key     = key_q;
  assign bus.core_din     = din_q;
  assign bus.core_decrypt = dec_q;
  assign bus.busy         = busy_q;
  assign bus.grant_id     = grant_q;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp0_data    = rsp0_valid_q ? res_q : '0;
  assign bus.rsp1_data    = rsp1_valid_q ? res_q : '0;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
  assign bus.rsp0_err     = rsp0_valid_q & err_q;
  assign bus.rsp1_err     = rsp1_valid_q & err_q;
`else
  assign bus.rsp0_err     = 1'b0;
  assign bus.rsp1_err     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      dec_q        <= 1'b0;
      key_q        <= '0;
      din_q        <= '0;
      res_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
      timer_q      <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            key_q        <= grant_sel ? bus.req1_key     : bus.req0_key;
            din_q        <= grant_sel ? bus.req1_data    : bus.req0_data;
            dec_q        <= grant_sel ? bus.req1_decrypt : bus.req0_decrypt;
            grant_q      <= grant_sel;
            busy_q       <= 1'b1;
            core_start_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_q <= 1'b0;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
          timer_q      <= '0;
`endif
          state_q      <= WAIT;
        end
        WAIT: begin
          // core_done has priority over a timeout landing on the same cycle.
          if (bus.core_done) begin
            res_q        <= bus.core_dout;
            rsp0_valid_q <= ~grant_q;
            rsp1_valid_q <= grant_q;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            state_q      <= RESP;
          end
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
          else if (timer_q == TIMER_LAST) begin
            res_q        <= '0;
            err_q        <= 1'b1;
            rsp0_valid_q <= ~grant_q;
            rsp1_valid_q <= grant_q;
            state_q      <= RESP;
          end else begin
            timer_q      <= timer_q + 16'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_sel) begin
            last_grant_q <= grant_q;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            key_q        <= '0;
            din_q        <= '0;
            dec_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: vector table for the main flow plus
// hand-written back-pressure, timeout/no-timeout and reset-mid-job sequences.
module tb_aes_core_arbiter;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 64;
`endif

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] D1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RB = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  aes_core_arbiter_if bus();

  aes_core_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       v0, v1, r0, r1, done;
    logic [1:0] dsel;
    logic       e_rdy0, e_rdy1, e_start, e_busy, e_gid, e_rv0, e_rv1;
    logic [1:0] e_rsel;
    logic [1:0] e_op;
  } vec_t;

  vec_t tbl[20];
  vec_t z;
  int total = 0;
  int bad   = 0;

  function automatic logic [127:0] res_of(input logic [1:0] s);
    case (s)
      2'd1:    return RA;
      2'd2:    return RB;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0_valid = v.v0;
    bus.req1_valid = v.v1;
    bus.rsp0_ready = v.r0;
    bus.rsp1_ready = v.r1;
    bus.core_done  = v.done;
    bus.core_dout  = res_of(v.dsel);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    logic [127:0] ek, ed;
    logic         edec;
    ek = (v.e_op == 2'd1) ? K0 : (v.e_op == 2'd2) ? K1 : '0;
    ed = (v.e_op == 2'd1) ? D0 : (v.e_op == 2'd2) ? D1 : '0;
    edec = (v.e_op == 2'd2);
    chk({tag, ".req0_ready"}, 128'(bus.req0_ready), 128'(v.e_rdy0));
    chk({tag, ".req1_ready"}, 128'(bus.req1_ready), 128'(v.e_rdy1));
    chk({tag, ".core_start"}, 128'(bus.core_start), 128'(v.e_start));
    chk({tag, ".busy"},       128'(bus.busy),       128'(v.e_busy));
    chk({tag, ".grant_id"},   128'(bus.grant_id),   128'(v.e_gid));
    chk({tag, ".rsp0_valid"}, 128'(bus.rsp0_valid), 128'(v.e_rv0));
    chk({tag, ".rsp1_valid"}, 128'(bus.rsp1_valid), 128'(v.e_rv1));
    chk({tag, ".rsp0_data"},  bus.rsp0_data, v.e_rv0 ? res_of(v.e_rsel) : 128'h0);
    chk({tag, ".rsp1_data"},  bus.rsp1_data, v.e_rv1 ? res_of(v.e_rsel) : 128'h0);
    chk({tag, ".rsp0_err"},   128'(bus.rsp0_err), 128'h0);
    chk({tag, ".rsp1_err"},   128'(bus.rsp1_err), 128'h0);
    chk({tag, ".core_key"},   bus.core_key, ek);
    chk({tag, ".core_din"},   bus.core_din, ed);
    chk({tag, ".core_decrypt"}, 128'(bus.core_decrypt), 128'(edec));
  endtask

  // Single-cycle step: inputs applied on the falling edge, outputs checked 1 time unit later.
  task automatic step(input vec_t v, input string tag);
    @(negedge clock);
    drive(v);
    #1;
    check_vec(tag, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    z = '{default: '0};
    //            v0 v1 r0 r1 dn ds  rd0 rd1 st bz gid rv0 rv1 rs op
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 0,  0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0,  1, 0, 1, 1};
    tbl[4]  = '{0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0,  1, 0, 1, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 1,  0, 0, 0, 2};
    tbl[8]  = '{1, 1, 0, 0, 1, 2,  0, 0, 0, 1, 1,  0, 0, 0, 2};
    tbl[9]  = '{1, 1, 0, 1, 0, 0,  0, 0, 0, 1, 1,  0, 1, 2, 2};
    tbl[10] = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[11] = '{1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 0, 0, 1};
    tbl[12] = '{1, 1, 0, 0, 1, 1,  0, 0, 0, 1, 0,  0, 0, 0, 1};
    tbl[13] = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0,  1, 0, 1, 1};
    tbl[14] = '{1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1,  0, 0, 0, 2};
    tbl[16] = '{0, 0, 0, 0, 1, 2,  0, 0, 0, 1, 1,  0, 0, 0, 2};
    tbl[17] = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1,  0, 1, 2, 2};
    tbl[18] = '{0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0};

    bus.req0_key = K0; bus.req0_data = D0; bus.req0_decrypt = 1'b0;
    bus.req1_key = K1; bus.req1_data = D1; bus.req1_decrypt = 1'b1;
    drive(z);
    reset = 1'b1;

    // Reset state, with a request offered that must not see ready.
    repeat (2) @(negedge clock);
    bus.req0_valid = 1'b1;
    #1;
    check_vec("reset", z);
    @(negedge clock);
    reset = 1'b0;
    drive(z);

    // Single job, contention alternation, stray done in IDLE.
    for (int i = 0; i < 20; i++) step(tbl[i], $sformatf("row%0d", i));

    // Back-pressure on rsp1 while req0 keeps asking.
    v = z; v.v1 = 1; v.e_rdy1 = 1;                                    step(v, "bp.accept");
    v = z; v.v0 = 1; v.e_start = 1; v.e_busy = 1; v.e_gid = 1; v.e_op = 2; step(v, "bp.issue");
    v = z; v.v0 = 1; v.done = 1; v.dsel = 2; v.e_busy = 1; v.e_gid = 1; v.e_op = 2; step(v, "bp.wait");
    for (int i = 0; i < 10; i++) begin
      v = z; v.v0 = 1; v.e_busy = 1; v.e_gid = 1; v.e_rv1 = 1; v.e_rsel = 2; v.e_op = 2;
      step(v, $sformatf("bp.hold%0d", i));
    end
    v = z; v.v0 = 1; v.r1 = 1; v.e_busy = 1; v.e_gid = 1; v.e_rv1 = 1; v.e_rsel = 2; v.e_op = 2; step(v, "bp.release");
    v = z; v.v0 = 1; v.e_rdy0 = 1;                                    step(v, "bp.next_accept");
    v = z; v.e_start = 1; v.e_busy = 1; v.e_op = 1;                   step(v, "bp.next_issue");
    v = z; v.done = 1; v.dsel = 1; v.e_busy = 1; v.e_op = 1;          step(v, "bp.next_wait");
    v = z; v.r0 = 1; v.e_busy = 1; v.e_rv0 = 1; v.e_rsel = 1; v.e_op = 1; step(v, "bp.next_resp");
    step(z, "bp.idle");

`ifdef AES_CORE_ARBITER_TIMEOUT_EN
    // No core_done: four WAIT cycles, then an error response with zero data.
    v = z; v.v0 = 1; v.e_rdy0 = 1;                                    step(v, "to.accept");
    v = z; v.e_start = 1; v.e_busy = 1; v.e_op = 1;                   step(v, "to.issue");
    for (int i = 0; i < 4; i++) begin
      v = z; v.e_busy = 1; v.e_op = 1;
      step(v, $sformatf("to.wait%0d", i));
    end
    @(negedge clock);
    drive(z);
    bus.rsp0_ready = 1'b1;
    #1;
    chk("to.rsp0_valid", 128'(bus.rsp0_valid), 128'h1);
    chk("to.rsp0_err",   128'(bus.rsp0_err),   128'h1);
    chk("to.rsp0_data",  bus.rsp0_data,        128'h0);
    chk("to.rsp1_valid", 128'(bus.rsp1_valid), 128'h0);
    step(z, "to.idle");

    // core_done on the last WAIT cycle beats the timeout.
    v = z; v.v0 = 1; v.e_rdy0 = 1;                                    step(v, "tl.accept");
    v = z; v.e_start = 1; v.e_busy = 1; v.e_op = 1;                   step(v, "tl.issue");
    for (int i = 0; i < 3; i++) begin
      v = z; v.e_busy = 1; v.e_op = 1;
      step(v, $sformatf("tl.wait%0d", i));
    end
    v = z; v.done = 1; v.dsel = 1; v.e_busy = 1; v.e_op = 1;          step(v, "tl.wait3");
    v = z; v.r0 = 1; v.e_busy = 1; v.e_rv0 = 1; v.e_rsel = 1; v.e_op = 1; step(v, "tl.resp");
    step(z, "tl.idle");
`else
    // Without the timeout, WAIT holds indefinitely.
    v = z; v.v0 = 1; v.e_rdy0 = 1;                                    step(v, "nt.accept");
    v = z; v.e_start = 1; v.e_busy = 1; v.e_op = 1;                   step(v, "nt.issue");
    for (int i = 0; i < 20; i++) begin
      v = z; v.e_busy = 1; v.e_op = 1;
      step(v, $sformatf("nt.wait%0d", i));
    end
    v = z; v.done = 1; v.dsel = 1; v.e_busy = 1; v.e_op = 1;          step(v, "nt.done");
    v = z; v.r0 = 1; v.e_busy = 1; v.e_rv0 = 1; v.e_rsel = 1; v.e_op = 1; step(v, "nt.resp");
    step(z, "nt.idle");
`endif

    // Reset pulsed mid-WAIT, then a late core_done.
    v = z; v.v1 = 1; v.e_rdy1 = 1;                                    step(v, "rw.accept");
    v = z; v.e_start = 1; v.e_busy = 1; v.e_gid = 1; v.e_op = 2;      step(v, "rw.issue");
    v = z; v.e_busy = 1; v.e_gid = 1; v.e_op = 2;                     step(v, "rw.wait");
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_vec("rw.in_reset", z);
    @(negedge clock);
    reset = 1'b0;
    v = z; v.done = 1; v.dsel = 2;                                    step(v, "rw.late_done");
    for (int i = 0; i < 3; i++) step(z, $sformatf("rw.after%0d", i));

    // After reset last_grant is 1, so req0 wins the first tie.
    @(negedge clock);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rw.tie.req0_ready", 128'(bus.req0_ready), 128'h1);
    chk("rw.tie.req1_ready", 128'(bus.req1_ready), 128'h0);
    drive(z);
    step(z, "rw.final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
